// File: rtl/mult_operand_feeder.sv
// Operand FIFO feeding a sequential shift-add multiplier: pops a pair, clears the
// multiplier, steps it MUL_CYCLES times, captures the product and holds it for handshake.
module mult_operand_feeder #(
  parameter int DEPTH      = 4,
  parameter int MUL_CYCLES = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_a,
  input  logic [5:0]               in_b,
  output logic [5:0]               mul_a,
  output logic [5:0]               mul_b,
  output logic                     mul_clr,
  output logic                     mul_load,
  input  logic [11:0]              mul_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [11:0]              res_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_STEP  = CW'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [5:0]    mul_a_q, mul_a_d;
  logic [5:0]    mul_b_q, mul_b_d;
  logic          clear_q, clear_d;
  logic          mul_load_q, mul_load_d;
  logic          res_valid_q, res_valid_d;
  logic [11:0]   res_data_q, res_data_d;

  logic [11:0]   fifo_mem [DEPTH];
  logic          push;
  logic          pop;

  // Pop decision uses the pre-edge count, so an entry arriving at an empty FIFO
  // is never consumed on the same edge it was written.
  assign push = in_valid && in_ready;
  assign pop  = (state_q == IDLE) && (count_q != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wptr_q] <= {in_a, in_b};
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          {mul_a_d, mul_b_d} = fifo_mem[rptr_q];
          state_d            = CLEAR;
        end
      end
      CLEAR: begin
        cyc_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (cyc_q == LAST_STEP) begin
          state_d = CAPTURE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      CAPTURE: begin
        cyc_d       = '0;
        res_data_d  = mul_out;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Control strobes are registered copies of the next state so they line up with it.
    clear_d    = (state_d == CLEAR);
    mul_load_d = (state_d == RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      cyc_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      clear_q     <= 1'b0;
      mul_load_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      cyc_q       <= cyc_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      clear_q     <= clear_d;
      mul_load_q  <= mul_load_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // The multiplier's own reset follows system reset so it never holds a stale product.
  assign mul_clr    = clear_q | reset;
  assign in_ready   = (count_q < FULL_COUNT);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_load   = mul_load_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;

endmodule
